issue_stage: RTL and testbench



---
 rtl/core_pkg.sv | 59 +++++
 rtl/issue_scoreboard.sv | 40 ++++
 rtl/issue_stage.sv | 202 ++++++++++++++++++++
 tb/tb_issue_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the issue stage.
//   dec_slot_t : one decoded instruction as delivered by decode
//   ex_lane_t  : registered control/operand bundle driven into one execute lane
//   is_ct()    : true for control transfers (branch or return)
package core_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int REG_W = $clog2(NREGS);

    // aluControl encoding
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_PASSB = 4'd9;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [3:0]       alu_ctrl;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             uses_rs2;
        logic             wr_en;
        logic             use_imm;
        logic [XLEN-1:0]  imm;
        logic             is_branch;
        logic             is_ret;
        logic             is_beq;
        logic             is_bgt;
        logic [XLEN-1:0]  br_target;
    } dec_slot_t;

    localparam int DEC_W = $bits(dec_slot_t);

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  opA;
        logic [XLEN-1:0]  opB;
        logic [XLEN-1:0]  br_target;
        logic [3:0]       alu_ctrl;
        logic [REG_W-1:0] rd;
        logic             wr_en;
        logic             is_branch;
        logic             is_ret;
        logic             is_beq;
        logic             is_bgt;
    } ex_lane_t;

    function automatic logic is_ct(input dec_slot_t s);
        return s.is_branch || s.is_ret;
    endfunction
endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: one busy bit per architectural register.
//   set_mask          : registers claimed by instructions issuing this cycle
//   wb0_* / wb1_*     : writeback completions clearing a busy bit
//   src / src_busy    : four combinational lookups against the registered vector
// A set and a clear of the same register in one cycle leaves it busy: the
// issuing instruction is the newer producer. r0 is never busy.
module issue_scoreboard #(
    parameter int  NREGS = 16,
    localparam int REG_W = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREGS-1:0]      set_mask,
    input  logic                  wb0_valid,
    input  logic [REG_W-1:0]      wb0_rd,
    input  logic                  wb1_valid,
    input  logic [REG_W-1:0]      wb1_rd,
    input  logic [3:0][REG_W-1:0] src,
    output logic [3:0]            src_busy
);
    localparam logic [NREGS-1:0] R0_MASK = {{(NREGS-1){1'b1}}, 1'b0};

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] clr;

    always_comb begin
        clr = '0;
        if (wb0_valid) clr[wb0_rd] = 1'b1;
        if (wb1_valid) clr[wb1_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= ((busy & ~clr) | set_mask) & R0_MASK;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) src_busy[i] = busy[src[i]];
    end
endmodule

// File: rtl/issue_stage.sv
// issue_stage: dual-lane in-order issue between decode and ExecuteUnit.
//   in_valid/in_ready/in_slot0/in_slot1 : decoded pair handshake (slot0 older)
//   rf_raddr/rf_rdata                   : combinational reads s0.rs1,s0.rs2,s1.rs1,s1.rs2
//   wb0_*/wb1_*                         : writeback completions (scoreboard clears)
//   br_resolved/br_taken                : outcome of the outstanding control transfer
//   ex0_*/ex1_*                         : registered lane outputs
// XLEN/NREGS must match the core_pkg values the slot struct is built from.
module issue_stage #(
    parameter int  XLEN  = 32,
    parameter int  NREGS = 16,
    localparam int REG_W = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [core_pkg::DEC_W-1:0] in_slot0,
    input  logic [core_pkg::DEC_W-1:0] in_slot1,
    output logic [3:0][REG_W-1:0]      rf_raddr,
    input  logic [3:0][XLEN-1:0]       rf_rdata,
    input  logic                       wb0_valid,
    input  logic [REG_W-1:0]           wb0_rd,
    input  logic                       wb1_valid,
    input  logic [REG_W-1:0]           wb1_rd,
    input  logic                       br_resolved,
    input  logic                       br_taken,
    output logic                       ex0_valid,
    output logic [XLEN-1:0]            ex0_pc,
    output logic [XLEN-1:0]            ex0_opA,
    output logic [XLEN-1:0]            ex0_opB,
    output logic [XLEN-1:0]            ex0_br_target,
    output logic [3:0]                 ex0_alu_ctrl,
    output logic [REG_W-1:0]           ex0_rd,
    output logic                       ex0_wr_en,
    output logic                       ex0_is_branch,
    output logic                       ex0_is_ret,
    output logic                       ex0_is_beq,
    output logic                       ex0_is_bgt,
    output logic                       ex1_valid,
    output logic [XLEN-1:0]            ex1_pc,
    output logic [XLEN-1:0]            ex1_opA,
    output logic [XLEN-1:0]            ex1_opB,
    output logic [XLEN-1:0]            ex1_br_target,
    output logic [3:0]                 ex1_alu_ctrl,
    output logic [REG_W-1:0]           ex1_rd,
    output logic                       ex1_wr_en,
    output logic                       ex1_is_branch,
    output logic                       ex1_is_ret,
    output logic                       ex1_is_beq,
    output logic                       ex1_is_bgt
);
    import core_pkg::dec_slot_t;
    import core_pkg::ex_lane_t;
    import core_pkg::is_ct;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_PAIR  = 2'd1;  // both slots pending (slot1 may be invalid)
    localparam logic [1:0] ST_SLOT1 = 2'd2;  // slot0 gone, slot1 pending

    logic [1:0]       state;
    dec_slot_t        buf0, buf1, head, s0_in, s1_in;
    logic             br_pending;
    logic [3:0]       src_busy;
    logic [NREGS-1:0] set_mask;
    logic             rsel, flush, head_rdy, s1_rdy, raw01, iss0, iss1, drained, accept;
    logic [XLEN-1:0]  head_a, head_b, s1_a, s1_b;
    ex_lane_t [1:0]   ex_q;
    logic [1:0]       ex_vld;

    function automatic logic [XLEN-1:0] src_val(input logic [REG_W-1:0] r,
                                                input logic [XLEN-1:0]  d);
        return (r == '0) ? '0 : d;
    endfunction

    function automatic ex_lane_t mk_lane(input dec_slot_t s, input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
        ex_lane_t l;
        l.pc        = s.pc;
        l.opA       = a;
        l.opB       = b;
        l.br_target = s.br_target;
        l.alu_ctrl  = s.alu_ctrl;
        l.rd        = s.rd;
        l.wr_en     = s.wr_en;
        l.is_branch = s.is_branch;
        l.is_ret    = s.is_ret;
        l.is_beq    = s.is_beq;
        l.is_bgt    = s.is_bgt;
        return l;
    endfunction

    assign s0_in = dec_slot_t'(in_slot0);
    assign s1_in = dec_slot_t'(in_slot1);

    assign rf_raddr[0] = buf0.rs1;
    assign rf_raddr[1] = buf0.rs2;
    assign rf_raddr[2] = buf1.rs1;
    assign rf_raddr[3] = buf1.rs2;

    issue_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_mask (set_mask),
        .wb0_valid(wb0_valid),
        .wb0_rd   (wb0_rd),
        .wb1_valid(wb1_valid),
        .wb1_rd   (wb1_rd),
        .src      (rf_raddr),
        .src_busy (src_busy)
    );

    // The oldest pending instruction always goes to lane 0; in SLOT1 that is
    // buf1, whose sources sit on read ports 2/3.
    assign rsel   = (state == ST_SLOT1);
    assign head   = rsel ? buf1 : buf0;
    assign head_a = src_val(head.rs1, rsel ? rf_rdata[2] : rf_rdata[0]);
    assign head_b = head.use_imm ? head.imm : src_val(head.rs2, rsel ? rf_rdata[3] : rf_rdata[1]);
    assign s1_a   = src_val(buf1.rs1, rf_rdata[2]);
    assign s1_b   = buf1.use_imm ? buf1.imm : src_val(buf1.rs2, rf_rdata[3]);

    assign head_rdy = !(rsel ? src_busy[2] : src_busy[0]) &&
                      (!head.uses_rs2 || !(rsel ? src_busy[3] : src_busy[1]));
    assign s1_rdy   = !src_busy[2] && (!buf1.uses_rs2 || !src_busy[3]);
    assign raw01    = buf0.wr_en && (buf0.rd != '0) &&
                      ((buf1.rs1 == buf0.rd) || (buf1.uses_rs2 && (buf1.rs2 == buf0.rd)));

    assign flush = br_resolved && br_taken;
    assign iss0  = (state != ST_EMPTY) && head.valid && head_rdy && !br_pending && !flush;
    assign iss1  = (state == ST_PAIR) && buf1.valid && iss0 && !is_ct(buf0) && s1_rdy && !raw01;

    assign drained  = (state == ST_EMPTY) ||
                      ((state == ST_PAIR) && iss0 && (iss1 || !buf1.valid)) ||
                      ((state == ST_SLOT1) && iss0);
    assign in_ready = drained || flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        set_mask = '0;
        if (iss0 && head.wr_en && head.rd != '0) set_mask[head.rd] = 1'b1;
        if (iss1 && buf1.wr_en && buf1.rd != '0) set_mask[buf1.rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            buf0       <= '0;
            buf1       <= '0;
            br_pending <= 1'b0;
            ex_q       <= '0;
            ex_vld     <= '0;
        end else begin
            // A pair accepted alongside a taken-branch flush is dropped.
            if (flush) begin
                state <= ST_EMPTY;
            end else if (accept) begin
                state <= s0_in.valid ? ST_PAIR : ST_EMPTY;
                buf0  <= s0_in;
                buf1  <= s1_in;
            end else if (state == ST_PAIR && iss0) begin
                state <= (iss1 || !buf1.valid) ? ST_EMPTY : ST_SLOT1;
            end else if (state == ST_SLOT1 && iss0) begin
                state <= ST_EMPTY;
            end

            if ((iss0 && is_ct(head)) || (iss1 && is_ct(buf1))) br_pending <= 1'b1;
            else if (br_resolved)                               br_pending <= 1'b0;

            // Lane fields hold their last value when the lane is idle.
            ex_vld <= {iss1, iss0};
            if (iss0) ex_q[0] <= mk_lane(head, head_a, head_b);
            if (iss1) ex_q[1] <= mk_lane(buf1, s1_a, s1_b);
        end
    end

    a_slot_order: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (s0_in.valid || !s1_in.valid));

    assign ex0_valid     = ex_vld[0];
    assign ex0_pc        = ex_q[0].pc;
    assign ex0_opA       = ex_q[0].opA;
    assign ex0_opB       = ex_q[0].opB;
    assign ex0_br_target = ex_q[0].br_target;
    assign ex0_alu_ctrl  = ex_q[0].alu_ctrl;
    assign ex0_rd        = ex_q[0].rd;
    assign ex0_wr_en     = ex_q[0].wr_en;
    assign ex0_is_branch = ex_q[0].is_branch;
    assign ex0_is_ret    = ex_q[0].is_ret;
    assign ex0_is_beq    = ex_q[0].is_beq;
    assign ex0_is_bgt    = ex_q[0].is_bgt;
    assign ex1_valid     = ex_vld[1];
    assign ex1_pc        = ex_q[1].pc;
    assign ex1_opA       = ex_q[1].opA;
    assign ex1_opB       = ex_q[1].opB;
    assign ex1_br_target = ex_q[1].br_target;
    assign ex1_alu_ctrl  = ex_q[1].alu_ctrl;
    assign ex1_rd        = ex_q[1].rd;
    assign ex1_wr_en     = ex_q[1].wr_en;
    assign ex1_is_branch = ex_q[1].is_branch;
    assign ex1_is_ret    = ex_q[1].is_ret;
    assign ex1_is_beq    = ex_q[1].is_beq;
    assign ex1_is_bgt    = ex_q[1].is_bgt;
endmodule

// File: tb/tb_issue_stage.sv
// tb_issue_stage: random decode/writeback/branch traffic against a queue-based
// reference of the issue rules; mid-run resets taken while a branch is pending.
module tb_issue_stage;
    import core_pkg::*;

    localparam int XL = 32;
    localparam int NR = 16;
    localparam int RW = 4;
    localparam int LW = 4 * XL + 4 + RW + 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               in_valid, in_ready;
    dec_slot_t          s0, s1;
    logic [3:0][RW-1:0] rf_raddr;
    logic [3:0][XL-1:0] rf_rdata;
    logic               wb0_valid, wb1_valid, br_resolved, br_taken;
    logic [RW-1:0]      wb0_rd, wb1_rd;
    logic               ex0_valid, ex0_wr_en, ex0_is_branch, ex0_is_ret, ex0_is_beq, ex0_is_bgt;
    logic               ex1_valid, ex1_wr_en, ex1_is_branch, ex1_is_ret, ex1_is_beq, ex1_is_bgt;
    logic [XL-1:0]      ex0_pc, ex0_opA, ex0_opB, ex0_br_target;
    logic [XL-1:0]      ex1_pc, ex1_opA, ex1_opB, ex1_br_target;
    logic [3:0]         ex0_alu_ctrl, ex1_alu_ctrl;
    logic [RW-1:0]      ex0_rd, ex1_rd;
    logic [LW-1:0]      lane0, lane1;

    logic [XL-1:0]      regs [NR];

    issue_stage #(.XLEN(XL), .NREGS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_slot0(s0), .in_slot1(s1), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
        .br_resolved(br_resolved), .br_taken(br_taken),
        .ex0_valid(ex0_valid), .ex0_pc(ex0_pc), .ex0_opA(ex0_opA), .ex0_opB(ex0_opB),
        .ex0_br_target(ex0_br_target), .ex0_alu_ctrl(ex0_alu_ctrl), .ex0_rd(ex0_rd),
        .ex0_wr_en(ex0_wr_en), .ex0_is_branch(ex0_is_branch), .ex0_is_ret(ex0_is_ret),
        .ex0_is_beq(ex0_is_beq), .ex0_is_bgt(ex0_is_bgt),
        .ex1_valid(ex1_valid), .ex1_pc(ex1_pc), .ex1_opA(ex1_opA), .ex1_opB(ex1_opB),
        .ex1_br_target(ex1_br_target), .ex1_alu_ctrl(ex1_alu_ctrl), .ex1_rd(ex1_rd),
        .ex1_wr_en(ex1_wr_en), .ex1_is_branch(ex1_is_branch), .ex1_is_ret(ex1_is_ret),
        .ex1_is_beq(ex1_is_beq), .ex1_is_bgt(ex1_is_bgt)
    );

    // Register file seen by the DUT; regs[0] holds junk so r0 forcing is visible.
    always_comb begin
        for (int i = 0; i < 4; i++) rf_rdata[i] = regs[rf_raddr[i]];
    end

    assign lane0 = {ex0_pc, ex0_opA, ex0_opB, ex0_br_target, ex0_alu_ctrl, ex0_rd,
                    ex0_wr_en, ex0_is_branch, ex0_is_ret, ex0_is_beq, ex0_is_bgt};
    assign lane1 = {ex1_pc, ex1_opA, ex1_opB, ex1_br_target, ex1_alu_ctrl, ex1_rd,
                    ex1_wr_en, ex1_is_branch, ex1_is_ret, ex1_is_beq, ex1_is_bgt};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // Reference state: pending instructions oldest first, busy bits, branch wait.
    dec_slot_t     pq[$];
    bit            busy[NR];
    bit            brp;
    bit            exp_vld[2];
    logic [LW-1:0] exp_lane[2];

    function automatic bit rdy(input dec_slot_t s);
        return (s.rs1 == 0 || !busy[s.rs1]) && (!s.uses_rs2 || s.rs2 == 0 || !busy[s.rs2]);
    endfunction

    function automatic bit reads_dest(input dec_slot_t older, input dec_slot_t younger);
        if (!older.wr_en || older.rd == 0) return 1'b0;
        return younger.rs1 == older.rd || (younger.uses_rs2 && younger.rs2 == older.rd);
    endfunction

    function automatic logic [LW-1:0] lane_of(input dec_slot_t s);
        logic [XL-1:0] a;
        logic [XL-1:0] b;
        a = (s.rs1 == 0) ? '0 : regs[s.rs1];
        b = s.use_imm ? s.imm : ((s.rs2 == 0) ? '0 : regs[s.rs2]);
        return {s.pc, a, b, s.br_target, s.alu_ctrl, s.rd,
                s.wr_en, s.is_branch, s.is_ret, s.is_beq, s.is_bgt};
    endfunction

    function automatic dec_slot_t rnd_slot();
        dec_slot_t s;
        s.valid     = 1'b1;
        s.pc        = $urandom;
        s.alu_ctrl  = 4'($urandom_range(0, 9));
        s.rs1       = 4'($urandom_range(0, 7));
        s.rs2       = 4'($urandom_range(0, 7));
        s.rd        = 4'($urandom_range(0, 7));
        s.uses_rs2  = 1'($urandom_range(0, 1));
        s.wr_en     = ($urandom_range(0, 9) < 7);
        s.use_imm   = ($urandom_range(0, 3) == 0);
        s.imm       = ($urandom_range(0, 3) == 0) ? 32'h2A : $urandom;
        s.is_branch = ($urandom_range(0, 9) == 0);
        s.is_ret    = !s.is_branch && ($urandom_range(0, 19) == 0);
        s.is_beq    = s.is_branch && ($urandom_range(0, 1) == 1);
        s.is_bgt    = s.is_branch && !s.is_beq;
        s.br_target = $urandom;
        return s;
    endfunction

    task automatic model_reset();
        pq.delete();
        for (int i = 0; i < NR; i++) busy[i] = 1'b0;
        brp = 1'b0;
        exp_vld[0] = 1'b0; exp_vld[1] = 1'b0;
        exp_lane[0] = '0;  exp_lane[1] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0; br_resolved = 1'b0;
        #1;
        chk("rst_ex0_valid", ex0_valid, 0);
        chk("rst_ex1_valid", ex1_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ex0_lane", lane0, 0);
        chk("rst_ex1_lane", lane1, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: check last edge's lane outputs, drive new inputs, predict.
    task automatic step();
        bit flush, i0, i1;
        int n;
        @(negedge clk);
        chk("ex0_valid", ex0_valid, exp_vld[0]);
        chk("ex1_valid", ex1_valid, exp_vld[1]);
        chk("ex0_lane", lane0, exp_lane[0]);
        chk("ex1_lane", lane1, exp_lane[1]);

        regs[$urandom_range(1, NR - 1)] = $urandom;
        in_valid    = ($urandom_range(0, 9) < 7);
        s0          = rnd_slot();
        s1          = rnd_slot();
        s1.valid    = ($urandom_range(0, 3) != 0);
        wb0_valid   = ($urandom_range(0, 2) == 0);
        wb0_rd      = 4'($urandom_range(0, 7));
        wb1_valid   = ($urandom_range(0, 2) == 0);
        wb1_rd      = 4'($urandom_range(0, 7));
        br_resolved = brp && ($urandom_range(0, 3) == 0);
        br_taken    = 1'($urandom_range(0, 1));
        #1;

        flush = br_resolved && br_taken;
        i0 = 1'b0;
        i1 = 1'b0;
        if (pq.size() > 0) i0 = !brp && !flush && rdy(pq[0]);
        if (i0 && pq.size() == 2) i1 = !is_ct(pq[0]) && rdy(pq[1]) && !reads_dest(pq[0], pq[1]);
        n = int'(i0) + int'(i1);

        chk("in_ready", in_ready, flush || (pq.size() == n));

        exp_vld[0] = i0;
        exp_vld[1] = i1;
        if (i0) exp_lane[0] = lane_of(pq[0]);
        if (i1) exp_lane[1] = lane_of(pq[1]);

        if (wb0_valid) busy[wb0_rd] = 1'b0;
        if (wb1_valid) busy[wb1_rd] = 1'b0;
        for (int k = 0; k < n; k++)
            if (pq[k].wr_en && pq[k].rd != 0) busy[pq[k].rd] = 1'b1;

        if ((i0 && is_ct(pq[0])) || (i1 && is_ct(pq[1]))) brp = 1'b1;
        else if (br_resolved)                              brp = 1'b0;

        repeat (n) void'(pq.pop_front());
        if (flush) pq.delete();
        else if (in_valid && pq.size() == 0) begin
            pq.push_back(s0);
            if (s1.valid) pq.push_back(s1);
        end
    endtask

    initial begin
        int rst_wait;
        in_valid = 1'b0; s0 = '0; s1 = '0;
        wb0_valid = 1'b0; wb0_rd = '0; wb1_valid = 1'b0; wb1_rd = '0;
        br_resolved = 1'b0; br_taken = 1'b0;
        regs[0] = 32'hDEAD_BEEF;
        for (int i = 1; i < NR; i++) regs[i] = $urandom;
        model_reset();
        do_reset();

        rst_wait = -1;
        for (int c = 0; c < 4000; c++) begin
            if (c == 1200 || c == 2600) rst_wait = 0;
            if (rst_wait >= 0 && ((brp && pq.size() == 2) || rst_wait > 400)) begin
                do_reset();
                rst_wait = -1;
            end else begin
                step();
                if (rst_wait >= 0) rst_wait++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
